// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map,
// defaults and the IRQ count bound.
package interrupt_controller_pkg;

    localparam int          MAX_IRQ             = 16;
    localparam int          ID_W                = 4;
    localparam logic [31:0] VECTOR_BASE_DEFAULT = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_IN_ISR = 2'd2,
        ST_RETURN = 2'd3
    } irq_state_e;

    typedef enum logic [1:0] {
        CFG_ENABLE  = 2'd0,
        CFG_PENDING = 2'd1,
        CFG_CTRL    = 2'd2,
        CFG_ACTIVE  = 2'd3
    } cfg_addr_e;

    // Each vector slot is one 32-bit word.
    function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                                input logic [ID_W-1:0] id);
        return base + {26'd0, id, 2'b00};
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: lowest set request index wins (index 0 highest).
module irq_priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[ID_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, non-nesting interrupt controller with a small config register
// file; it redirects the core to a vector on entry and back to the saved PC on RETI.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter logic [31:0] VECTOR_BASE = VECTOR_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic               instr_boundary,
    input  logic [31:0]        pc_next,
    input  logic               end_isr,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               take_irq,
    output logic [31:0]        isr_vector,
    output logic               ret_valid,
    output logic [31:0]        ret_pc
);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic               global_en_q, global_en_d;
    logic [31:0]        saved_pc_q, saved_pc_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [NUM_IRQ-1:0] irq_hist_q, irq_hist_d;
    logic               primed_q, primed_d;

    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [ID_W-1:0]    win_idx;
    logic               win_valid;
    logic               in_isr;
    logic               unused_wdata;

    assign eligible     = pending_q & enable_q;
    assign unused_wdata = ^cfg_wdata;

    irq_priority_encoder #(
        .WIDTH (NUM_IRQ)
    ) u_prio (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        global_en_d = global_en_q;
        saved_pc_d  = saved_pc_q;
        active_id_d = active_id_q;
        irq_hist_d  = irq_lines;
        primed_d    = 1'b1;

        // The first cycle out of reset only samples history, so a line already high is not an edge.
        rise = irq_lines & ~irq_hist_q & {NUM_IRQ{primed_q}};
        clr  = '0;

        if (cfg_we) begin
            case (cfg_addr)
                CFG_ENABLE:  enable_d    = cfg_wdata[NUM_IRQ-1:0];
                CFG_PENDING: clr         = cfg_wdata[NUM_IRQ-1:0];
                CFG_CTRL:    global_en_d = cfg_wdata[0];
                default:     ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (global_en_q && win_valid && instr_boundary) begin
                    state_d     = ST_ENTER;
                    saved_pc_d  = pc_next;
                    active_id_d = win_idx;
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (win_idx == ID_W'(i)) clr[i] = 1'b1;
                    end
                end
            end
            ST_ENTER:  state_d = ST_IN_ISR;
            ST_IN_ISR: if (end_isr && instr_boundary) state_d = ST_RETURN;
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // A new edge in the same cycle as any clear keeps the request.
        pending_d = (pending_q & ~clr) | rise;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            enable_q    <= '0;
            global_en_q <= 1'b0;
            saved_pc_q  <= '0;
            active_id_q <= '0;
            irq_hist_q  <= '0;
            primed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            global_en_q <= global_en_d;
            saved_pc_q  <= saved_pc_d;
            active_id_q <= active_id_d;
            irq_hist_q  <= irq_hist_d;
            primed_q    <= primed_d;
        end
    end

    assign in_isr     = (state_q != ST_IDLE);
    assign take_irq   = (state_q == ST_ENTER);
    assign ret_valid  = (state_q == ST_RETURN);
    assign isr_vector = vector_addr(VECTOR_BASE, active_id_q);
    assign ret_pc     = saved_pc_q;

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_ENABLE:  cfg_rdata[NUM_IRQ-1:0] = enable_q;
            CFG_PENDING: cfg_rdata[NUM_IRQ-1:0] = pending_q;
            CFG_CTRL:    cfg_rdata[0]           = global_en_q;
            CFG_ACTIVE: begin
                cfg_rdata[31]       = in_isr;
                cfg_rdata[ID_W-1:0] = active_id_q;
            end
            default:     cfg_rdata = '0;
        endcase
    end

endmodule
